// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Forward selects, FSM states and the register-match rule live here.
package hazard_ctrl_unit_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_t;

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } state_t;

   // Index 0 is hardwired on most ISAs, so it can optionally never match.
   function automatic logic reg_match(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic        zero_en);
      return (a == b) && (!zero_en || (a != 32'd0));
   endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Combinational EX-operand forward select for one source register.
// EX/MEM is checked first so the newest producer wins.
module hazard_ctrl_unit_fwd_sel
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int REGFILE_LEN = 6,
   parameter bit ZERO_REG_EN = 1'b1
) (
   input  logic [REGFILE_LEN-1:0] rs,
   input  logic [REGFILE_LEN-1:0] rd_mem,
   input  logic                   reg_write_mem,
   input  logic [REGFILE_LEN-1:0] rd_wb,
   input  logic                   reg_write_wb,
   output logic [1:0]             sel
);

   logic match_mem;
   logic match_wb;

   assign match_mem = reg_write_mem && reg_match(32'(rs), 32'(rd_mem), ZERO_REG_EN);
   assign match_wb  = reg_write_wb  && reg_match(32'(rs), 32'(rd_wb),  ZERO_REG_EN);

   always_comb begin
      sel = FWD_RF;
      if (match_mem) begin
         sel = FWD_MEM;
      end else if (match_wb) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, multi-cycle
// freezes, EX forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int REGFILE_LEN = 6,
   parameter int LOAD_LAT    = 1,
   parameter bit ZERO_REG_EN = 1'b1,
   parameter int PERF_W      = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REGFILE_LEN-1:0] rs1_IF_ID,
   input  logic [REGFILE_LEN-1:0] rs2_IF_ID,
   input  logic [REGFILE_LEN-1:0] rs1_ID_EX,
   input  logic [REGFILE_LEN-1:0] rs2_ID_EX,
   input  logic [REGFILE_LEN-1:0] rd_ID_EX,
   input  logic                   mem_read_ID_EX,
   input  logic [REGFILE_LEN-1:0] rd_EX_MEM,
   input  logic                   reg_write_EX_MEM,
   input  logic [REGFILE_LEN-1:0] rd_MEM_WB,
   input  logic                   reg_write_MEM_WB,
   input  logic                   branch_taken_EX,
   input  logic                   mc_busy,
   output logic                   stall_IF,
   output logic                   stall_ID,
   output logic                   flush_IF_ID,
   output logic                   flush_ID_EX,
   output logic                   load_stall,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b,
   output logic [PERF_W-1:0]      stall_cycles
);

   localparam int CNT_W = $clog2(LOAD_LAT + 1);

   state_t            state_reg;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [CNT_W-1:0]  cnt_next;
   logic [PERF_W-1:0] perf_reg;
   logic              haz;
   logic [1:0]        sel_a;
   logic [1:0]        sel_b;

   assign haz = mem_read_ID_EX &&
                (reg_match(32'(rd_ID_EX), 32'(rs1_IF_ID), ZERO_REG_EN) ||
                 reg_match(32'(rd_ID_EX), 32'(rs2_IF_ID), ZERO_REG_EN));

   // Controls must react in the same cycle the hazard appears, so they are
   // decoded from the registered state plus the live inputs.
   always_comb begin
      stall_IF    = 1'b0;
      stall_ID    = 1'b0;
      flush_IF_ID = 1'b0;
      flush_ID_EX = 1'b0;
      load_stall  = 1'b0;
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      if (!rst) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else if (mc_busy) begin
         stall_IF = 1'b1;
         stall_ID = 1'b1;
      end else if (branch_taken_EX) begin
         flush_IF_ID = 1'b1;
         flush_ID_EX = 1'b1;
         state_next  = IDLE;
         cnt_next    = '0;
      end else if (state_reg == LOAD_WAIT) begin
         stall_IF    = 1'b1;
         stall_ID    = 1'b1;
         flush_ID_EX = 1'b1;
         load_stall  = 1'b1;
         cnt_next    = cnt_reg - CNT_W'(1);
         if (cnt_reg == CNT_W'(1)) begin
            state_next = IDLE;
         end
      end else if (haz) begin
         stall_IF    = 1'b1;
         stall_ID    = 1'b1;
         flush_ID_EX = 1'b1;
         load_stall  = 1'b1;
         if (LOAD_LAT > 1) begin
            cnt_next   = CNT_W'(LOAD_LAT - 1);
            state_next = LOAD_WAIT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_reg <= '0;
      end else if (stall_IF && (perf_reg != {PERF_W{1'b1}})) begin
         perf_reg <= perf_reg + PERF_W'(1);
      end
   end

   assign stall_cycles = perf_reg;

   hazard_ctrl_unit_fwd_sel #(
      .REGFILE_LEN (REGFILE_LEN),
      .ZERO_REG_EN (ZERO_REG_EN)
   ) u_fwd_sel_a (
      .rs            (rs1_ID_EX),
      .rd_mem        (rd_EX_MEM),
      .reg_write_mem (reg_write_EX_MEM),
      .rd_wb         (rd_MEM_WB),
      .reg_write_wb  (reg_write_MEM_WB),
      .sel           (sel_a)
   );

   hazard_ctrl_unit_fwd_sel #(
      .REGFILE_LEN (REGFILE_LEN),
      .ZERO_REG_EN (ZERO_REG_EN)
   ) u_fwd_sel_b (
      .rs            (rs2_ID_EX),
      .rd_mem        (rd_EX_MEM),
      .reg_write_mem (reg_write_EX_MEM),
      .rd_wb         (rd_MEM_WB),
      .reg_write_wb  (reg_write_MEM_WB),
      .sel           (sel_b)
   );

   assign fwd_a = rst ? sel_a : FWD_RF;
   assign fwd_b = rst ? sel_b : FWD_RF;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three configurations share one stimulus stream
// and are checked every cycle against a bubbles-remaining behavioural model.
module tb_hazard_ctrl_unit;

   localparam int NI = 3;
   localparam int LAT [NI] = '{1, 3, 1};
   localparam longint MAXC [NI] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] rs1_IF_ID, rs2_IF_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX;
   logic [5:0] rd_EX_MEM, rd_MEM_WB;
   logic       mem_read_ID_EX, reg_write_EX_MEM, reg_write_MEM_WB;
   logic       branch_taken_EX, mc_busy;

   logic        s_if [NI];
   logic        s_id [NI];
   logic        f_ifid [NI];
   logic        f_idex [NI];
   logic        ls [NI];
   logic [1:0]  fa [NI];
   logic [1:0]  fb [NI];
   logic [31:0] sc [NI];
   logic [31:0] sc0, sc1;
   logic [3:0]  sc2;

   int     total = 0;
   int     bad = 0;
   int     bub [NI];
   longint mcnt [NI];

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.REGFILE_LEN(6), .LOAD_LAT(1), .ZERO_REG_EN(1'b1), .PERF_W(32)) u_lat1 (
      .clk(clk), .rst(rst), .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
      .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
      .mem_read_ID_EX(mem_read_ID_EX), .rd_EX_MEM(rd_EX_MEM), .reg_write_EX_MEM(reg_write_EX_MEM),
      .rd_MEM_WB(rd_MEM_WB), .reg_write_MEM_WB(reg_write_MEM_WB), .branch_taken_EX(branch_taken_EX),
      .mc_busy(mc_busy), .stall_IF(s_if[0]), .stall_ID(s_id[0]), .flush_IF_ID(f_ifid[0]),
      .flush_ID_EX(f_idex[0]), .load_stall(ls[0]), .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_cycles(sc0));

   hazard_ctrl_unit #(.REGFILE_LEN(6), .LOAD_LAT(3), .ZERO_REG_EN(1'b1), .PERF_W(32)) u_lat3 (
      .clk(clk), .rst(rst), .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
      .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
      .mem_read_ID_EX(mem_read_ID_EX), .rd_EX_MEM(rd_EX_MEM), .reg_write_EX_MEM(reg_write_EX_MEM),
      .rd_MEM_WB(rd_MEM_WB), .reg_write_MEM_WB(reg_write_MEM_WB), .branch_taken_EX(branch_taken_EX),
      .mc_busy(mc_busy), .stall_IF(s_if[1]), .stall_ID(s_id[1]), .flush_IF_ID(f_ifid[1]),
      .flush_ID_EX(f_idex[1]), .load_stall(ls[1]), .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_cycles(sc1));

   hazard_ctrl_unit #(.REGFILE_LEN(6), .LOAD_LAT(1), .ZERO_REG_EN(1'b1), .PERF_W(4)) u_perf4 (
      .clk(clk), .rst(rst), .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
      .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
      .mem_read_ID_EX(mem_read_ID_EX), .rd_EX_MEM(rd_EX_MEM), .reg_write_EX_MEM(reg_write_EX_MEM),
      .rd_MEM_WB(rd_MEM_WB), .reg_write_MEM_WB(reg_write_MEM_WB), .branch_taken_EX(branch_taken_EX),
      .mc_busy(mc_busy), .stall_IF(s_if[2]), .stall_ID(s_id[2]), .flush_IF_ID(f_ifid[2]),
      .flush_ID_EX(f_idex[2]), .load_stall(ls[2]), .fwd_a(fa[2]), .fwd_b(fb[2]), .stall_cycles(sc2));

   assign sc[0] = sc0;
   assign sc[1] = sc1;
   assign sc[2] = {28'd0, sc2};

   function automatic bit same(input logic [5:0] a, input logic [5:0] b);
      return (a == b) && (a != 6'd0);
   endfunction

   function automatic bit load_use();
      return mem_read_ID_EX && (same(rd_ID_EX, rs1_IF_ID) || same(rd_ID_EX, rs2_IF_ID));
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [5:0] src);
      if (!rst) return 2'd0;
      if (reg_write_EX_MEM && same(rd_EX_MEM, src)) return 2'd2;
      if (reg_write_MEM_WB && same(rd_MEM_WB, src)) return 2'd1;
      return 2'd0;
   endfunction

   // {stall_IF, stall_ID, flush_IF_ID, flush_ID_EX, load_stall}
   function automatic logic [4:0] exp_ctrl(input int k);
      if (!rst) return 5'b00000;
      if (mc_busy) return 5'b11000;
      if (branch_taken_EX) return 5'b00110;
      if (bub[k] > 0 || load_use()) return 5'b11011;
      return 5'b00000;
   endfunction

   always @(posedge clk or negedge rst) begin
      for (int k = 0; k < NI; k++) begin
         if (!rst) begin
            bub[k]  = 0;
            mcnt[k] = 0;
         end else begin
            logic [4:0] c;
            c = exp_ctrl(k);
            if (c[4] && mcnt[k] < MAXC[k]) mcnt[k] = mcnt[k] + 1;
            if (mc_busy) begin
               // frozen
            end else if (branch_taken_EX) begin
               bub[k] = 0;
            end else if (bub[k] > 0) begin
               bub[k] = bub[k] - 1;
            end else if (load_use()) begin
               bub[k] = LAT[k] - 1;
            end
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("ctrl[%0d]", k),
             longint'({s_if[k], s_id[k], f_ifid[k], f_idex[k], ls[k]}), longint'(exp_ctrl(k)));
         chk($sformatf("fwd_a[%0d]", k), longint'(fa[k]), longint'(exp_fwd(rs1_ID_EX)));
         chk($sformatf("fwd_b[%0d]", k), longint'(fb[k]), longint'(exp_fwd(rs2_ID_EX)));
         chk($sformatf("stall_cycles[%0d]", k), longint'(sc[k]), mcnt[k]);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rs1_IF_ID = 0; rs2_IF_ID = 0; rs1_ID_EX = 0; rs2_ID_EX = 0; rd_ID_EX = 0;
      rd_EX_MEM = 0; rd_MEM_WB = 0; mem_read_ID_EX = 0; reg_write_EX_MEM = 0;
      reg_write_MEM_WB = 0; branch_taken_EX = 0; mc_busy = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      next();
      rst = 1'b1;
   endtask

   task automatic set_hazard(input bit on);
      mem_read_ID_EX = on;
      rd_ID_EX       = on ? 6'd5 : 6'd0;
      rs1_IF_ID      = on ? 6'd5 : 6'd0;
   endtask

   initial begin
      clear_inputs();
      fork
         forever begin
            @(negedge clk);
            compare_all();
         end
      join_none
      next();
      @(negedge clk);
      chk("reset_sif", longint'(s_if[1]), 0);
      chk("reset_sc", longint'(sc[1]), 0);
      next();
      rst = 1'b1;

      // single-cycle load-use hazard
      set_hazard(1);
      @(negedge clk);
      chk("lu_lat1_c0", longint'(ls[0]), 1);
      chk("lu_lat1_flush_c0", longint'(f_idex[0]), 1);
      chk("lu_lat3_c0", longint'(ls[1]), 1);
      next(); set_hazard(0);
      @(negedge clk);
      chk("lu_lat1_c1", longint'(ls[0]), 0);
      chk("lu_lat3_c1", longint'(ls[1]), 1);
      next();
      @(negedge clk);
      chk("lu_lat3_c2", longint'(ls[1]), 1);
      next();
      @(negedge clk);
      chk("lu_lat3_c3", longint'(ls[1]), 0);
      chk("lu_sc_lat1", longint'(sc[0]), 1);
      chk("lu_sc_lat3", longint'(sc[1]), 3);

      // zero register never hazards or forwards
      do_reset();
      mem_read_ID_EX = 1; rd_ID_EX = 0; rs2_IF_ID = 0;
      rd_EX_MEM = 0; reg_write_EX_MEM = 1; rs1_ID_EX = 0;
      @(negedge clk);
      chk("zero_nostall", longint'(s_if[1]), 0);
      chk("zero_fwd_a", longint'(fa[0]), 0);

      // forwarding priority
      next();
      mem_read_ID_EX = 0;
      rd_EX_MEM = 7; rd_MEM_WB = 7; reg_write_EX_MEM = 1; reg_write_MEM_WB = 1;
      rs1_ID_EX = 7; rs2_ID_EX = 7;
      @(negedge clk);
      chk("fwd_both_a", longint'(fa[0]), 2);
      chk("fwd_both_b", longint'(fb[0]), 2);
      next(); reg_write_EX_MEM = 0;
      @(negedge clk);
      chk("fwd_wb_a", longint'(fa[0]), 1);
      chk("fwd_wb_b", longint'(fb[0]), 1);
      next(); reg_write_EX_MEM = 1; rd_EX_MEM = 4; rs1_ID_EX = 4;
      @(negedge clk);
      chk("fwd_split_a", longint'(fa[1]), 2);
      chk("fwd_split_b", longint'(fb[1]), 1);

      // branch during the second bubble cycle
      do_reset();
      set_hazard(1);
      next(); set_hazard(0); branch_taken_EX = 1;
      @(negedge clk);
      chk("br_flush_ifid", longint'(f_ifid[1]), 1);
      chk("br_flush_idex", longint'(f_idex[1]), 1);
      chk("br_sif", longint'(s_if[1]), 0);
      next(); branch_taken_EX = 0;
      @(negedge clk);
      chk("br_idle", longint'(ls[1]), 0);

      // multi-cycle freeze in IDLE and inside LOAD_WAIT
      do_reset();
      set_hazard(1); mc_busy = 1;
      @(negedge clk);
      chk("mc_sif", longint'(s_if[1]), 1);
      chk("mc_flush", longint'(f_idex[1]), 0);
      chk("mc_ls", longint'(ls[1]), 0);
      next(); mc_busy = 0;
      @(negedge clk);
      chk("mc_rel_c1", longint'(ls[1]), 1);
      next(); set_hazard(0); mc_busy = 1;
      @(negedge clk);
      chk("mc_frz_ls", longint'(ls[1]), 0);
      chk("mc_frz_sif", longint'(s_if[1]), 1);
      next(); mc_busy = 0;
      @(negedge clk);
      chk("mc_res_c3", longint'(ls[1]), 1);
      next();
      @(negedge clk);
      chk("mc_res_c4", longint'(ls[1]), 1);
      next();
      @(negedge clk);
      chk("mc_res_c5", longint'(ls[1]), 0);
      chk("mc_sc", longint'(sc[1]), 5);

      // asynchronous reset inside LOAD_WAIT
      do_reset();
      set_hazard(1);
      next(); set_hazard(0);
      next();
      rst = 1'b0;
      #1;
      chk("rst_mid_sif", longint'(s_if[1]), 0);
      chk("rst_mid_ls", longint'(ls[1]), 0);
      chk("rst_mid_sc", longint'(sc[1]), 0);
      next(); rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_idle", longint'(ls[1]), 0);

      // counter saturation
      do_reset();
      mc_busy = 1;
      repeat (20) next();
      mc_busy = 0;
      @(negedge clk);
      chk("sat_perf4", longint'(sc[2]), 15);
      chk("sat_perf32", longint'(sc[0]), 20);
      next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller. It sits beside the IF/ID/EX/MEM/WB pipeline registers and generates four kinds of control:
- load-use stalls, with a configurable number of bubble cycles;
- branch flushes;
- freezes for a multi-cycle execution unit;
- EX-stage operand forwarding selects.

It also keeps a saturating stall-cycle performance counter.

Parameters:
REGFILE_LEN, 6, register index width.
LOAD_LAT, 1, bubble cycles per load-use hazard; legal range 1..8.
ZERO_REG_EN, 1, when 1, index 0 never creates a hazard or forward.
PERF_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-low.
rs1_IF_ID  in  REGFILE_LEN  source 1 of the instruction in ID.
rs2_IF_ID  in  REGFILE_LEN  source 2 of the instruction in ID.
rs1_ID_EX  in  REGFILE_LEN  source 1 of the instruction in EX.
rs2_ID_EX  in  REGFILE_LEN  source 2 of the instruction in EX.
rd_ID_EX  in  REGFILE_LEN  destination of the instruction in EX.
mem_read_ID_EX  in  1  instruction in EX is a load.
rd_EX_MEM  in  REGFILE_LEN  destination in MEM.
reg_write_EX_MEM  in  1  instruction in MEM writes rd.
rd_MEM_WB  in  REGFILE_LEN  destination in WB.
reg_write_MEM_WB  in  1  instruction in WB writes rd.
branch_taken_EX  in  1  branch/jump redirect resolved in EX.
mc_busy  in  1  multi-cycle unit (divider) is occupying EX.
stall_IF  out  1  hold the PC and the IF/ID register.
stall_ID  out  1  hold the IF/ID contents.
flush_IF_ID  out  1  zero the IF/ID register.
flush_ID_EX  out  1  insert a bubble into ID/EX.
load_stall  out  1  a load-use stall is active this cycle.
fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
fwd_b  out  2  EX operand B select, same encoding as fwd_a.
stall_cycles  out  PERF_W  saturating count of cycles in which stall_IF was 1.

Behaviour:
- Reset, rst=0, asynchronous:
  - FSM goes to IDLE, the bubble counter to 0, stall_cycles to 0.
  - All outputs are 0 while rst=0.
- Register match rule: a source and destination match only if the indices are equal AND (ZERO_REG_EN=0 OR index≠0).
- Load-use hazard (combinational):
  - haz = mem_read_ID_EX & (rd_ID_EX matches rs1_IF_ID OR rd_ID_EX matches rs2_IF_ID).
- FSM states: IDLE and LOAD_WAIT; bubble counter width is clog2(LOAD_LAT+1).
  - IDLE with haz=1:
    - load_stall, stall_IF, stall_ID and flush_ID_EX are all 1 in the same cycle.
    - If LOAD_LAT>1, the counter loads LOAD_LAT-1 and the FSM moves to LOAD_WAIT.
    - Otherwise the FSM stays in IDLE.
  - LOAD_WAIT:
    - load_stall, stall_IF, stall_ID and flush_ID_EX stay 1 regardless of haz, because the bubble has already cleared rd_ID_EX.
    - The counter decrements each cycle.
    - When counter==1, the next state is IDLE.
  - Result: exactly LOAD_LAT bubble cycles per hazard.
- Priority, highest first:
  1. mc_busy=1:
     - stall_IF=stall_ID=1; flush_IF_ID=flush_ID_EX=0; load_stall=0.
     - FSM state and counter are frozen.
  2. branch_taken_EX=1:
     - flush_IF_ID=flush_ID_EX=1; stall_IF=stall_ID=0; load_stall=0.
     - FSM forced to IDLE and counter cleared, because the hazarding instruction is squashed.
  3. Load-use stall as described above.
  4. None of the above: all control outputs are 0.
- Forwarding (combinational, independent of stalls; shown for A, B identical using rs2_ID_EX):
  - fwd_a=10 if reg_write_EX_MEM and rd_EX_MEM matches rs1_ID_EX.
  - Else fwd_a=01 if reg_write_MEM_WB and rd_MEM_WB matches rs1_ID_EX.
  - Else fwd_a=00.
  - EX/MEM has priority over MEM/WB when both match (newest value wins).
- stall_cycles:
  - Increments on each clk edge where stall_IF=1.
  - Saturates at all-ones and never wraps.
- Reset mid-stall: asserting rst in LOAD_WAIT returns the FSM to IDLE immediately, with all outputs 0.

Decomposition:
- Shared package:
  - fwd select encodings: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encodings: IDLE, LOAD_WAIT.
- One sub-module, fwd_sel:
  - purely combinational;
  - inputs: one source index plus the EX/MEM and MEM/WB destinations and write enables;
  - output: a 2-bit select;
  - instantiated twice, for operands A and B.

Test Plan:
- LOAD_LAT=1: mem_read_ID_EX=1, rd_ID_EX=5, rs1_IF_ID=5 for one cycle -> load_stall, stall_IF and flush_ID_EX are 1 for exactly 1 cycle, then 0; stall_cycles=1.
- LOAD_LAT=3, same hazard presented for one cycle only -> stall for exactly 3 consecutive cycles; FSM returns to IDLE; stall_cycles=3.
- ZERO_REG_EN=1: load with rd_ID_EX=0, rs2_IF_ID=0 -> no stall. Forward check: rd_EX_MEM=0, reg_write_EX_MEM=1, rs1_ID_EX=0 -> fwd_a=00.
- rd_EX_MEM=7 and rd_MEM_WB=7, both write enables 1, rs1_ID_EX=rs2_ID_EX=7 -> fwd_a=fwd_b=10. Drop reg_write_EX_MEM -> both become 01.
- LOAD_LAT=3: branch_taken_EX=1 in the 2nd stall cycle -> flush_IF_ID=flush_ID_EX=1, stall_IF=0, FSM in IDLE on the next cycle. Separately, mc_busy=1 together with a hazard -> stall_IF=1, flush_ID_EX=0, counter frozen until mc_busy=0.
- rst=0 in the middle of LOAD_WAIT -> all outputs 0 immediately and stall_cycles=0. Separately, PERF_W=4 with 20 stall cycles -> stall_cycles holds at 15.
